// File: rtl/sm_run_ctrl.sv
// sm_run_ctrl: run / halt / single-step sequencer for the sm_cpu core.
// Drives the CPU clock enable from host commands, an optional PC breakpoint
// and an optional enabled-cycle budget, and reports why the core stopped.
// Optional feature macro: SM_RUN_CTRL_BREAKPOINT_EN (PC breakpoint logic).
// Without it the breakpoint inputs are ignored and cause 3 is never reported.
module sm_run_ctrl #(
    parameter int CYC_W        = 32,
    parameter int MAX_CYCLES   = 0,
    parameter bit RUN_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [CYC_W-1:0] cmd_arg,
    output logic             cmd_ready,
    input  logic [31:0]      pc,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    output logic             cpu_en,
    output logic             halted,
    output logic [2:0]       halt_cause,
    output logic [CYC_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
    } state_t;

    localparam logic [1:0] OP_RUN  = 2'd0;
    localparam logic [1:0] OP_HALT = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_CLR  = 2'd3;

    localparam logic [2:0] CAUSE_RESET   = 3'd0;
    localparam logic [2:0] CAUSE_HALT    = 3'd1;
    localparam logic [2:0] CAUSE_STEP    = 3'd2;
    localparam logic [2:0] CAUSE_BP      = 3'd3;
    localparam logic [2:0] CAUSE_TIMEOUT = 3'd4;

    localparam logic [CYC_W-1:0] CNT_ZERO = {CYC_W{1'b0}};
    localparam logic [CYC_W-1:0] CNT_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};
    localparam logic [CYC_W-1:0] CNT_MAX  = {CYC_W{1'b1}};
    localparam logic [CYC_W-1:0] MAX_C    = CYC_W'(MAX_CYCLES);

    localparam state_t RESET_STATE = RUN_ON_RESET ? ST_RUN : ST_HALTED;

    state_t           state_r, state_n_s;
    logic [2:0]       cause_r, cause_n_s;
    logic [CYC_W-1:0] cycle_cnt_r, cycle_cnt_n_s;
    logic [CYC_W-1:0] step_cnt_r, step_cnt_n_s;
    logic             halted_r;

    logic cmd_fire_s;
    logic run_cmd_s, halt_cmd_s, step_cmd_s, clr_cmd_s;
    logic bp_hit_s;
    logic cpu_en_s;
    logic limit_s;       // counter at or past the budget: RUN/STEP refused
    logic last_cyc_s;    // counter one below the budget
    logic timeout_hit_s;

    // Commands are always accepted outside reset; no back-pressure.
    assign cmd_ready  = ~rst;
    assign cmd_fire_s = cmd_valid & ~rst;
    assign run_cmd_s  = cmd_fire_s & (cmd_op == OP_RUN);
    assign halt_cmd_s = cmd_fire_s & (cmd_op == OP_HALT);
    assign step_cmd_s = cmd_fire_s & (cmd_op == OP_STEP);
    assign clr_cmd_s  = cmd_fire_s & (cmd_op == OP_CLR);

    // The budget only exists when MAX_CYCLES is non-zero.
    generate
        if (MAX_CYCLES != 0) begin : g_timeout
            assign limit_s    = (cycle_cnt_r >= MAX_C);
            assign last_cyc_s = (cycle_cnt_r == (MAX_C - CNT_ONE));
        end else begin : g_no_timeout
            assign limit_s    = 1'b0;
            assign last_cyc_s = 1'b0;
        end
    endgenerate

`ifdef SM_RUN_CTRL_BREAKPOINT_EN
    logic bp_skip_r, bp_skip_n_s;

    // The first instruction after a resume is allowed past the breakpoint.
    assign bp_hit_s = bp_en & (pc == bp_addr) & ~bp_skip_r;

    // Arm skip on leaving HALTED, drop it once one instruction has executed.
    always_comb begin
        bp_skip_n_s = bp_skip_r;
        if ((state_r == ST_HALTED) && (state_n_s != ST_HALTED)) begin
            bp_skip_n_s = 1'b1;
        end else if (cpu_en_s) begin
            bp_skip_n_s = 1'b0;
        end else begin
            bp_skip_n_s = bp_skip_r;
        end
    end

    // Breakpoint skip flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_skip_r <= 1'b0;
        end else begin
            bp_skip_r <= bp_skip_n_s;
        end
    end
`else
    logic unused_bp_s;

    assign bp_hit_s    = 1'b0;
    assign unused_bp_s = ^{bp_en, bp_addr, pc};
`endif

    // Zero-latency enable so a breakpoint blocks the instruction at bp_addr.
    assign cpu_en_s      = ~rst & ((state_r == ST_RUN) | (state_r == ST_STEP)) & ~bp_hit_s;
    assign timeout_hit_s = cpu_en_s & last_cyc_s & ~clr_cmd_s;

    // Next-state, cause, counters; halt sources follow HALT > BP > TIMEOUT > STEP_DONE.
    always_comb begin
        state_n_s     = state_r;
        cause_n_s     = cause_r;
        step_cnt_n_s  = step_cnt_r;
        cycle_cnt_n_s = cycle_cnt_r;

        if (clr_cmd_s) begin
            cycle_cnt_n_s = CNT_ZERO;
        end else if (cpu_en_s && (cycle_cnt_r != CNT_MAX)) begin
            cycle_cnt_n_s = cycle_cnt_r + CNT_ONE;
        end else begin
            cycle_cnt_n_s = cycle_cnt_r;
        end

        if (cpu_en_s && (state_r == ST_STEP)) begin
            step_cnt_n_s = step_cnt_r - CNT_ONE;
        end else begin
            step_cnt_n_s = step_cnt_r;
        end

        case (state_r)
            ST_HALTED: begin
                if (run_cmd_s && !limit_s) begin
                    state_n_s = ST_RUN;
                end else if (step_cmd_s && !limit_s) begin
                    state_n_s    = ST_STEP;
                    step_cnt_n_s = (cmd_arg == CNT_ZERO) ? CNT_ONE : cmd_arg;
                end else begin
                    state_n_s = ST_HALTED;
                end
            end
            ST_RUN, ST_STEP: begin
                if (halt_cmd_s) begin
                    state_n_s = ST_HALTED;
                    cause_n_s = CAUSE_HALT;
                end else if (bp_hit_s) begin
                    state_n_s = ST_HALTED;
                    cause_n_s = CAUSE_BP;
                end else if (timeout_hit_s) begin
                    state_n_s = ST_HALTED;
                    cause_n_s = CAUSE_TIMEOUT;
                end else if ((state_r == ST_STEP) && cpu_en_s && (step_cnt_r == CNT_ONE)) begin
                    state_n_s = ST_HALTED;
                    cause_n_s = CAUSE_STEP;
                end else begin
                    state_n_s = state_r;
                end
            end
            default: begin
                state_n_s = ST_HALTED;
                cause_n_s = CAUSE_RESET;
            end
        endcase
    end

    // State, cause, counters and the registered halted flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= RESET_STATE;
            cause_r     <= CAUSE_RESET;
            cycle_cnt_r <= CNT_ZERO;
            step_cnt_r  <= CNT_ZERO;
            halted_r    <= !RUN_ON_RESET;
        end else begin
            state_r     <= state_n_s;
            cause_r     <= cause_n_s;
            cycle_cnt_r <= cycle_cnt_n_s;
            step_cnt_r  <= step_cnt_n_s;
            halted_r    <= (state_n_s == ST_HALTED);
        end
    end

    assign cpu_en     = cpu_en_s;
    assign halted     = halted_r;
    assign halt_cause = cause_r;
    assign cycle_cnt  = cycle_cnt_r;

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Directed bench for sm_run_ctrl: table of per-cycle command vectors plus
// hand-written sequences for timeout, breakpoint and reset-mid-step.
module tb_sm_run_ctrl;

    localparam logic [1:0] OP_RUN  = 2'd0;
    localparam logic [1:0] OP_HALT = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_CLR  = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic [31:0] pc;
    logic        bp_en;
    logic [31:0] bp_addr;

    logic        cmd_ready_a, cpu_en_a, halted_a;
    logic [2:0]  cause_a;
    logic [31:0] cnt_a;
    logic        cmd_ready_b, cpu_en_b, halted_b;
    logic [2:0]  cause_b;
    logic [31:0] cnt_b;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        vld;
        logic [1:0]  op;
        logic [31:0] arg;
        logic        en;
        logic        hlt;
        logic [2:0]  cause;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[23];

    // Main DUT: starts halted, 120-cycle budget.
    sm_run_ctrl #(.CYC_W(32), .MAX_CYCLES(120), .RUN_ON_RESET(1'b0)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .cmd_ready(cmd_ready_a), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
        .cpu_en(cpu_en_a), .halted(halted_a), .halt_cause(cause_a), .cycle_cnt(cnt_a)
    );

    // Second DUT: runs out of reset, no budget.
    sm_run_ctrl #(.CYC_W(32), .MAX_CYCLES(0), .RUN_ON_RESET(1'b1)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .cmd_ready(cmd_ready_b), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
        .cpu_en(cpu_en_b), .halted(halted_b), .halt_cause(cause_b), .cycle_cnt(cnt_b)
    );

    // Clock generator.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; the bench CPU model advances pc by 4 on each enabled cycle.
    task automatic tick();
        logic en_before;
        en_before = cpu_en_a;
        @(posedge clk);
        #1;
        if (en_before) pc = pc + 32'd4;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_arg   = 32'd0;
    endtask

    function automatic vec_t mk(input logic vld, input logic [1:0] op, input logic [31:0] arg,
                                input logic en, input logic hlt, input logic [2:0] cause,
                                input logic [31:0] cnt);
        vec_t v;
        v.vld = vld; v.op = op; v.arg = arg;
        v.en = en; v.hlt = hlt; v.cause = cause; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        int en_seen;
        // vld op arg | cpu_en during cycle | halted cause cnt after edge
        vecs[0]  = mk(1'b0, OP_RUN,  32'd0, 1'b0, 1'b1, 3'd0, 32'd0);
        vecs[1]  = mk(1'b0, OP_RUN,  32'd0, 1'b0, 1'b1, 3'd0, 32'd0);
        vecs[2]  = mk(1'b1, OP_STEP, 32'd3, 1'b0, 1'b0, 3'd0, 32'd0);
        vecs[3]  = mk(1'b0, OP_RUN,  32'd0, 1'b1, 1'b0, 3'd0, 32'd1);
        vecs[4]  = mk(1'b0, OP_RUN,  32'd0, 1'b1, 1'b0, 3'd0, 32'd2);
        vecs[5]  = mk(1'b0, OP_RUN,  32'd0, 1'b1, 1'b1, 3'd2, 32'd3);
        vecs[6]  = mk(1'b0, OP_RUN,  32'd0, 1'b0, 1'b1, 3'd2, 32'd3);
        vecs[7]  = mk(1'b1, OP_STEP, 32'd0, 1'b0, 1'b0, 3'd2, 32'd3);
        vecs[8]  = mk(1'b0, OP_RUN,  32'd0, 1'b1, 1'b1, 3'd2, 32'd4);
        vecs[9]  = mk(1'b1, OP_CLR,  32'd0, 1'b0, 1'b1, 3'd2, 32'd0);
        vecs[10] = mk(1'b1, OP_RUN,  32'd0, 1'b0, 1'b0, 3'd2, 32'd0);
        vecs[11] = mk(1'b0, OP_RUN,  32'd0, 1'b1, 1'b0, 3'd2, 32'd1);
        vecs[12] = mk(1'b1, OP_RUN,  32'd0, 1'b1, 1'b0, 3'd2, 32'd2);
        vecs[13] = mk(1'b1, OP_CLR,  32'd0, 1'b1, 1'b0, 3'd2, 32'd0);
        vecs[14] = mk(1'b0, OP_RUN,  32'd0, 1'b1, 1'b0, 3'd2, 32'd1);
        vecs[15] = mk(1'b1, OP_HALT, 32'd0, 1'b1, 1'b1, 3'd1, 32'd2);
        vecs[16] = mk(1'b1, OP_HALT, 32'd0, 1'b0, 1'b1, 3'd1, 32'd2);
        vecs[17] = mk(1'b1, OP_STEP, 32'd2, 1'b0, 1'b0, 3'd1, 32'd2);
        vecs[18] = mk(1'b1, OP_HALT, 32'd0, 1'b1, 1'b1, 3'd1, 32'd3);
        vecs[19] = mk(1'b0, OP_RUN,  32'd0, 1'b0, 1'b1, 3'd1, 32'd3);
        vecs[20] = mk(1'b1, OP_RUN,  32'd0, 1'b0, 1'b0, 3'd1, 32'd3);
        vecs[21] = mk(1'b1, OP_STEP, 32'd7, 1'b1, 1'b0, 3'd1, 32'd4);
        vecs[22] = mk(1'b1, OP_HALT, 32'd0, 1'b1, 1'b1, 3'd1, 32'd5);

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 32'd0;
        pc = 32'd0; bp_en = 1'b0; bp_addr = 32'd0;

        // Reset values while rst is held.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready_a", cmd_ready_a, 1'b0);
        check("rst_en_a", cpu_en_a, 1'b0);
        check("rst_halted_a", halted_a, 1'b1);
        check("rst_ready_b", cmd_ready_b, 1'b0);
        check("rst_en_b", cpu_en_b, 1'b0);
        check("rst_halted_b", halted_b, 1'b0);
        rst = 1'b0;
        #1;
        check("rel_ready_a", cmd_ready_a, 1'b1);
        check("rel_cause_a", cause_a, 3'd0);
        check("rel_cnt_a", cnt_a, 32'd0);
        check("rel_en_b", cpu_en_b, 1'b1);

        // Table: step, step-0, clear, run, halt, ignored commands.
        for (int i = 0; i < 23; i++) begin
            cmd_valid = vecs[i].vld;
            cmd_op    = vecs[i].op;
            cmd_arg   = vecs[i].arg;
            #1;
            check($sformatf("v%0d_en", i), cpu_en_a, vecs[i].en);
            tick();
            cmd_valid = 1'b0;
            check($sformatf("v%0d_halted", i), halted_a, vecs[i].hlt);
            check($sformatf("v%0d_cause", i), cause_a, vecs[i].cause);
            check($sformatf("v%0d_cnt", i), cnt_a, vecs[i].cnt);
        end

        // Timeout after 120 enabled cycles.
        send(OP_CLR, 32'd0);
        send(OP_RUN, 32'd0);
        en_seen = 0;
        for (int i = 0; i < 200 && !halted_a; i++) begin
            if (cpu_en_a) en_seen++;
            tick();
        end
        check("to_halted", halted_a, 1'b1);
        check("to_cause", cause_a, 3'd4);
        check("to_cnt", cnt_a, 32'd120);
        check("to_en_cycles", en_seen, 32'd120);
        send(OP_RUN, 32'd0);
        check("to_run_ignored", halted_a, 1'b1);
        check("to_run_ignored_en", cpu_en_a, 1'b0);
        send(OP_STEP, 32'd5);
        check("to_step_ignored", halted_a, 1'b1);
        send(OP_CLR, 32'd0);
        check("to_clr_cnt", cnt_a, 32'd0);
        send(OP_RUN, 32'd0);
        check("to_resume_halted", halted_a, 1'b0);
        check("to_resume_en", cpu_en_a, 1'b1);
        send(OP_HALT, 32'd0);
        check("to_halt_cause", cause_a, 3'd1);

        // Breakpoint at 0x10 from pc 0.
        pc = 32'd0; bp_en = 1'b1; bp_addr = 32'h10;
        send(OP_CLR, 32'd0);
        send(OP_RUN, 32'd0);
        for (int i = 0; i < 20 && !halted_a; i++) begin
            tick();
        end
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
        check("bp_halted", halted_a, 1'b1);
        check("bp_cause", cause_a, 3'd3);
        check("bp_pc", pc, 32'h10);
        check("bp_cnt", cnt_a, 32'd4);
        send(OP_RUN, 32'd0);
        check("bp_resume_en", cpu_en_a, 1'b1);
        tick();
        check("bp_resume_pc", pc, 32'h14);
        bp_addr = 32'h14;
        #1;
        check("bp_hit_en", cpu_en_a, 1'b0);
        send(OP_HALT, 32'd0);
        check("bp_vs_halt_cause", cause_a, 3'd1);
        check("bp_vs_halt_pc", pc, 32'h14);
`else
        check("nobp_halted", halted_a, 1'b0);
        check("nobp_pc", pc, 32'h50);
        check("nobp_cnt", cnt_a, 32'd20);
        send(OP_HALT, 32'd0);
        check("nobp_halt_cause", cause_a, 3'd1);
`endif
        bp_en = 1'b0;

        // Reset in the middle of STEP 10.
        send(OP_CLR, 32'd0);
        send(OP_STEP, 32'd10);
        repeat (4) tick();
        check("ms_cnt", cnt_a, 32'd4);
        check("ms_en", cpu_en_a, 1'b1);
        rst = 1'b1;
        #1;
        check("ms_rst_en_a", cpu_en_a, 1'b0);
        check("ms_rst_cnt_a", cnt_a, 32'd0);
        check("ms_rst_halted_a", halted_a, 1'b1);
        check("ms_rst_cause_a", cause_a, 3'd0);
        check("ms_rst_ready_a", cmd_ready_a, 1'b0);
        check("ms_rst_en_b", cpu_en_b, 1'b0);
        check("ms_rst_cnt_b", cnt_b, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("ms_post_en_a%0d", i), cpu_en_a, 1'b0);
            tick();
            check($sformatf("ms_post_halted_a%0d", i), halted_a, 1'b1);
        end
        check("ms_post_cnt_a", cnt_a, 32'd0);
        check("ms_post_en_b", cpu_en_b, 1'b1);
        check("ms_post_halted_b", halted_b, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
